// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//   Shares one external combinational ALU (ADD/SUB/AND/OR) between two
//   requesters. A round-robin grant selects a requester in IDLE; the accepted
//   operands are driven to the ALU for one EXEC cycle; the registered
//   result/carry are then held on the owner's response channel until taken.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake (N = 0,1)
//   reqN_a/b/sel             request operands and op select
//   rspN_valid/ready         response handshake (N = 0,1)
//   rsp_result, rsp_carry    shared registered response data
//   alu_a/b/sel              operands to the shared ALU (registered)
//   alu_result, alu_carry    ALU outputs
module alu_rr_arbiter #(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last;   // requester served most recently
  logic   owner;  // requester of the operation in flight
  logic   gnt;    // combinational grant: 0 -> req0, 1 -> req1

  // On a tie the requester not served last wins; otherwise the lone valid one.
  always_comb begin
    gnt = req1_valid;
    if (req0_valid && req1_valid) gnt = ~last;
  end

  // Readys are combinational so a valid raised in IDLE is taken that cycle;
  // gated by rst so nothing is accepted while reset is applied.
  assign req0_ready = !rst && (state == IDLE) && req0_valid && !gnt;
  assign req1_ready = !rst && (state == IDLE) && req1_valid &&  gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_a   <= req0_a;
            alu_b   <= req0_b;
            alu_sel <= req0_sel;
            owner   <= 1'b0;
            last    <= 1'b0;
            state   <= EXEC;
          end else if (req1_ready) begin
            alu_a   <= req1_a;
            alu_b   <= req1_b;
            alu_sel <= req1_sel;
            owner   <= 1'b1;
            last    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          // Upper select bit marks the logic ops, whose ALU carry is garbage.
          rsp_carry  <= alu_sel[SEL_W-1] ? 1'b0 : alu_carry;
          rsp0_valid <= !owner;
          rsp1_valid <=  owner;
          state      <= RESP;
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios followed by random traffic,
// all checked each cycle against a transaction-level reference model.
module tb_alu_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_sel, req1_sel;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_sel;
  logic       alu_carry;
  logic       junk;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.DATA_W(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  // External ALU stand-in; logic ops drive an arbitrary carry.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_sel)
      2'b00:   {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      2'b10:   begin alu_result = alu_a & alu_b; alu_carry = junk; end
      default: begin alu_result = alu_a | alu_b; alu_carry = junk; end
    endcase
  end

  // Reference model state (transaction level)
  bit         pend;      // an accepted op has not yet been returned
  int         acc;       // cycle number of the accepting edge
  bit         own;
  bit         last;
  logic [3:0] er, ma, mb;
  logic [1:0] ms;
  bit         ec;
  bit         prev_rst;
  int         cyc;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void ref_op(input logic [3:0] a, input logic [3:0] b,
                                 input logic [1:0] s,
                                 output logic [3:0] r, output bit c);
    int x;
    int ia = int'(a);
    int ib = int'(b);
    case (s)
      2'd0: begin x = ia + ib; r = 4'(x % 16); c = (x > 15); end
      2'd1: begin x = ia - ib; r = 4'((x + 16) % 16); c = (x < 0); end
      2'd2: begin r = a & b; c = 0; end
      default: begin r = a | b; c = 0; end
    endcase
  endfunction

  task automatic step(input bit r,
                      input bit v0, input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] s0,
                      input bit v1, input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] s1,
                      input bit k0, input bit k1, input bit j);
    bit         w;
    logic [1:0] rdy, rv;
    rst = r; junk = j;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
    rsp0_ready = k0; rsp1_ready = k1;
    @(negedge clk);
    w   = (v0 && v1) ? !last : v1;
    rdy = (!r && !pend && (v0 || v1)) ? (w ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", 8'(rdy), 8'({req1_ready, req0_ready}));
    // note: argument order is (got, exp)
    rv = (pend && cyc >= acc + 2) ? (own ? 2'b10 : 2'b01) : 2'b00;
    chk("rsp_valid", 8'({rsp1_valid, rsp0_valid}), 8'(rv));
    if (rv != 2'b00) begin
      chk("rsp_result", 8'(rsp_result), 8'(er));
      chk("rsp_carry", 8'(rsp_carry), 8'(ec));
    end
    if (prev_rst) begin
      chk("rst_result", 8'(rsp_result), 8'h0);
      chk("rst_carry", 8'(rsp_carry), 8'h0);
    end
    chk("alu_a", 8'(alu_a), 8'(ma));
    chk("alu_b", 8'(alu_b), 8'(mb));
    chk("alu_sel", 8'(alu_sel), 8'(ms));
    @(posedge clk);
    if (r) begin
      pend = 0; last = 1; ma = '0; mb = '0; ms = '0;
    end else if (!pend) begin
      if (v0 || v1) begin
        pend = 1; acc = cyc; own = w; last = w;
        ma = w ? a1 : a0; mb = w ? b1 : b0; ms = w ? s1 : s0;
        ref_op(ma, mb, ms, er, ec);
      end
    end else if (cyc >= acc + 2 && (own ? k1 : k0)) begin
      pend = 0;
    end
    prev_rst = r;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
  endtask

  initial begin
    pend = 0; last = 1; ma = '0; mb = '0; ms = '0; er = '0; ec = 0;
    acc = 0; own = 0; cyc = 0; prev_rst = 1;
    rst = 1; junk = 0;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_sel = '0;
    rsp0_ready = 0; rsp1_ready = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // req0 ADD 9+8 -> 1, carry 1
    step(0, 1, 4'h9, 4'h8, 2'd0, 0, 0, 0, 0, 1, 1, 0);
    idle(4);
    // req1 SUB 3-5 -> E borrow; 5-3 -> 2
    step(0, 0, 0, 0, 0, 1, 4'h3, 4'h5, 2'd1, 1, 1, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 1, 4'h5, 4'h3, 2'd1, 1, 1, 0);
    idle(3);
    // Fresh reset, then both valid every cycle: grants alternate from req0
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 15; i++)
      step(0, 1, 4'(i), 4'h7, 2'(i), 1, 4'hF - 4'(i), 4'h2, 2'(i + 1), 1, 1, 0);
    idle(3);
    // AND C&A -> 8; OR with ALU carry forced to 1 -> E, carry 0
    step(0, 1, 4'hC, 4'hA, 2'd2, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(2);
    step(0, 1, 4'hC, 4'hA, 2'd3, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(2);
    // Response back-pressure with both requesters waiting
    step(0, 1, 4'h6, 4'h7, 2'd0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 4'h1, 4'h1, 2'd0, 1, 4'h2, 4'h2, 2'd0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 4'h1, 4'h1, 2'd0, 1, 4'h2, 4'h2, 2'd0, 1, 1, 0);
    idle(3);
    // Reset during EXEC, then a tie goes to req0
    step(0, 0, 0, 0, 0, 1, 4'hA, 4'h5, 2'd0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(2);
    step(0, 1, 4'h2, 4'h2, 2'd0, 1, 4'h3, 4'h3, 2'd0, 1, 1, 0);
    idle(3);
    // Reset during RESP (response held off), then a tie goes to req0
    step(0, 0, 0, 0, 0, 1, 4'hB, 4'h4, 2'd1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 4'h4, 4'h9, 2'd1, 1, 4'h8, 4'h8, 2'd0, 1, 1, 0);
    idle(3);

    // Random traffic with occasional reset
    for (int i = 0; i < 1500; i++)
      step($urandom_range(63) == 0,
           1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
           $urandom_range(3) != 0, $urandom_range(3) != 0, 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
